// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared types and defaults for the CNN pixel-stream blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int c_default_data_w = 8;
    localparam int c_default_ch     = 16;

    // One channel-vector pixel at the default geometry.
    typedef logic signed [c_default_data_w-1:0] pix_vec_t [c_default_ch];

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } upsample_state_t;

    // Counter width that stays at least one bit when the range is 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/upsample2x_row_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : row_buffer
//  Description : Single-row pixel store: one synchronous write port and one
//                combinational read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module row_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH  = 14,
    parameter int WIDTH  = 128,
    parameter int ADDR_W = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the accepted pixel into its column slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/upsample2x.sv
`default_nettype none
// ============================================================================
//  Module      : upsample2x
//  Description : 2x nearest-neighbour upsampler on a raster channel-vector
//                stream. Buffers one input row, then replays each pixel twice
//                horizontally and the whole doubled row twice vertically.
//  Revision    : 1.0 - initial release
// ============================================================================
module upsample2x
    import cnn_pkg::*;
#(
    parameter int CH     = c_default_ch,
    parameter int DATA_W = c_default_data_w,
    parameter int IN_W   = 14,
    parameter int IN_H   = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CH*DATA_W-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CH*DATA_W-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    localparam int c_vec_w  = CH * DATA_W;
    localparam int c_icol_w = cnt_w(IN_W);
    localparam int c_irow_w = cnt_w(IN_H);
    // $clog2(2*IN_W) is exactly one bit wider than $clog2(IN_W) for IN_W>=2,
    // so dropping the LSB of an output column yields an input column.
    localparam int c_ocol_w = cnt_w(2 * IN_W);

    localparam logic [c_icol_w-1:0] c_icol_last = c_icol_w'(IN_W - 1);
    localparam logic [c_irow_w-1:0] c_irow_last = c_irow_w'(IN_H - 1);
    localparam logic [c_ocol_w-1:0] c_ocol_last = c_ocol_w'(2 * IN_W - 1);

    upsample_state_t       r_state;
    upsample_state_t       w_state_nxt;
    logic [c_icol_w-1:0]   r_in_col;
    logic [c_irow_w-1:0]   r_in_row;
    logic [c_ocol_w-1:0]   r_out_col;
    logic                  r_rep;

    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_in_row_done;
    logic                  w_col_end;
    logic                  w_row_end;
    logic [c_ocol_w-1:0]   w_ocol_nxt;
    logic                  w_rep_nxt;
    logic                  w_last_nxt;
    logic [c_icol_w-1:0]   w_rd_addr;
    logic [c_vec_w-1:0]    w_rd_data;

    assign w_in_xfer     = in_valid && in_ready;
    assign w_out_xfer    = out_valid && out_ready;
    assign w_in_row_done = w_in_xfer && (r_in_col == c_icol_last);
    assign w_col_end     = (r_out_col == c_ocol_last);
    assign w_row_end     = w_col_end && r_rep;

    // Position of the element that follows the one currently presented.
    assign w_ocol_nxt = w_col_end ? '0 : r_out_col + c_ocol_w'(1);
    assign w_rep_nxt  = w_col_end ? 1'b1 : r_rep;
    assign w_last_nxt = (r_in_row == c_irow_last) && w_rep_nxt
                        && (w_ocol_nxt == c_ocol_last);

    // FILL loads column 0 for the first output; EMIT prefetches the next one.
    assign w_rd_addr = (r_state == EMIT) ? w_ocol_nxt[c_ocol_w-1:1] : '0;

    row_buffer #(
        .DEPTH (IN_W),
        .WIDTH (c_vec_w)
    ) u_row_buffer (
        .clk     (clk),
        .wr_en   (w_in_xfer),
        .wr_addr (r_in_col),
        .wr_data (in_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and input-side ready.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (w_in_row_done) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (w_out_xfer && w_row_end) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Counters and registered output vector, valid and last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_col  <= '0;
            r_in_row  <= '0;
            r_out_col <= '0;
            r_rep     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                if (w_in_row_done) begin
                    r_in_col  <= '0;
                    r_out_col <= '0;
                    r_rep     <= 1'b0;
                    out_data  <= w_rd_data;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                end else begin
                    r_in_col <= r_in_col + c_icol_w'(1);
                end
            end
            if ((r_state == EMIT) && w_out_xfer) begin
                if (w_row_end) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    r_in_row  <= (r_in_row == c_irow_last) ? '0
                                 : r_in_row + c_irow_w'(1);
                end else begin
                    r_out_col <= w_ocol_nxt;
                    r_rep     <= w_rep_nxt;
                    out_data  <= w_rd_data;
                    out_last  <= w_last_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_upsample2x.sv
`default_nettype none
// ============================================================================
//  Module      : tb_upsample2x
//  Description : Self-checking bench for upsample2x: default 14x14x16 instance
//                plus a 2x2x2 corner instance driven from a vector table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upsample2x;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Default geometry instance
    logic [127:0] a_in_data = '0;
    logic         a_in_valid = 1'b0;
    logic         a_in_ready;
    logic [127:0] a_out_data;
    logic         a_out_valid;
    logic         a_out_ready = 1'b0;
    logic         a_out_last;

    // Corner geometry instance
    logic [15:0]  b_in_data = '0;
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [15:0]  b_out_data;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;
    logic         b_out_last;

    int n_vec = 0;
    int n_err = 0;
    int g_row = 0;

    logic [127:0] fpix [14][14];

    typedef struct {
        logic [15:0] in_pix;
        logic [15:0] exp_data;
        logic        exp_last;
    } bvec_t;

    bvec_t btab [16];
    int    b_e0 [16] = '{5, 5, -3, -3, 5, 5, -3, -3, 7, 7, 9, 9, 7, 7, 9, 9};
    int    b_ip [4]  = '{5, -3, 7, 9};

    always #5 clk = ~clk;

    upsample2x #(.CH(16), .DATA_W(8), .IN_W(14), .IN_H(14)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_last  (a_out_last)
    );

    upsample2x #(.CH(2), .DATA_W(8), .IN_W(2), .IN_H(2)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_last  (b_out_last)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Frame pattern mixing the signed extremes with a position-dependent value.
    function automatic logic [127:0] mk_pix(input int r, input int col);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < 16; c++) begin
            case ((r + col + c) % 4)
                0:       v[c*8 +: 8] = 8'h80;
                1:       v[c*8 +: 8] = 8'h7f;
                2:       v[c*8 +: 8] = 8'hff;
                default: v[c*8 +: 8] = 8'(r * 14 + col);
            endcase
        end
        return v;
    endfunction

    // One input row through the default instance, in_valid held high all the
    // time; returns early once abort_at outputs have transferred.
    task automatic run_row_a(input int r, input bit rnd, input int abort_at);
        int in_idx = 0;
        int out_idx = 0;
        int cyc = 0;
        logic [127:0] exp_d;
        logic exp_l;
        while (out_idx < 56) begin
            if (cyc > 2000) begin
                n_vec++;
                n_err++;
                $display("FAIL a_timeout: row %0d got %0d outputs expected 56", r, out_idx);
                return;
            end
            a_in_valid  = 1'b1;
            a_in_data   = (in_idx < 14) ? fpix[r][in_idx] : {4{$urandom()}};
            a_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_idx < 14) begin
                chk("a_fill_hs", {a_in_ready, a_out_valid}, 2'b10);
            end else begin
                chk("a_emit_hs", {a_in_ready, a_out_valid}, 2'b01);
                exp_d = fpix[r][(out_idx % 28) / 2];
                exp_l = (g_row == 13) && (out_idx == 55);
                chk("a_data", a_out_data, exp_d);
                chk("a_last", a_out_last, exp_l);
            end
            if (a_in_valid && a_in_ready) in_idx++;
            if (a_out_valid && a_out_ready) out_idx++;
            @(posedge clk);
            #1;
            cyc++;
            if (out_idx == abort_at) return;
        end
        chk("a_rowend_hs", {a_in_ready, a_out_valid}, 2'b10);
        g_row = (g_row + 1) % 14;
    endtask

    // Asynchronous reset pulse away from the clock edge.
    task automatic do_reset();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_a_valid", a_out_valid, 1'b0);
        chk("rst_a_last",  a_out_last, 1'b0);
        chk("rst_a_ready", a_in_ready, 1'b1);
        #3;
        rst_n = 1'b1;
        g_row = 0;
    endtask

    initial begin
        int in_k;
        int cyc;

        for (int k = 0; k < 16; k++) begin
            btab[k].in_pix   = (k < 4) ? {8'(-b_ip[k]), 8'(b_ip[k])} : 16'h0;
            btab[k].exp_data = {8'(-b_e0[k]), 8'(b_e0[k])};
            btab[k].exp_last = (k == 15);
        end
        for (int c = 0; c < 14; c++) fpix[0][c] = 128'(c);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", a_out_valid, 1'b0);
        chk("rst_last",  a_out_last, 1'b0);
        chk("rst_ready", a_in_ready, 1'b1);
        chk("rst_data",  a_out_data, '0);
        chk("rst_b_hs",  {b_in_ready, b_out_valid, b_out_last}, 3'b100);
        rst_n = 1'b1;

        // Column-index row at full rate, then with random back-pressure
        run_row_a(0, 1'b0, -1);
        run_row_a(0, 1'b1, -1);

        // Reset after output transfer 20, then the row replays from column 0
        run_row_a(0, 1'b1, 20);
        do_reset();
        run_row_a(0, 1'b0, -1);

        // Two full frames of signed extreme patterns
        do_reset();
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 14; c++) fpix[r][c] = mk_pix(r, c);
        for (int r = 0; r < 14; r++) run_row_a(r, r[0], -1);
        for (int r = 0; r < 14; r++) run_row_a(r, 1'b1, -1);
        a_in_valid = 1'b0;

        // Corner configuration, table-driven
        in_k = 0;
        for (int k = 0; k < 16; k++) begin
            cyc = 0;
            while (!b_out_valid && cyc < 50) begin
                b_in_valid = (in_k < 4);
                b_in_data  = btab[(in_k < 4) ? in_k : 0].in_pix;
                if (b_in_valid && b_in_ready) in_k++;
                @(posedge clk);
                #1;
                cyc++;
            end
            b_in_valid = 1'b0;
            chk("b_data", b_out_data, btab[k].exp_data);
            chk("b_last", b_out_last, btab[k].exp_last);
            if (k % 3 == 1) begin
                @(posedge clk);
                #1;
                chk("b_hold", b_out_data, btab[k].exp_data);
            end
            b_out_ready = 1'b1;
            @(posedge clk);
            #1;
            b_out_ready = 1'b0;
        end
        chk("b_end_hs", {b_in_ready, b_out_valid}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
